sliding_window_kxk: RTL and testbench
=====================================

# sliding_window_kxk

Parametrised K×K sliding-window generator for the CNN convolution front end. It accepts a raster-order pixel stream and emits one flattened K×K window per eligible pixel position. It supports configurable kernel size, stride, image width and height, and ready/valid backpressure on both sides. Frame boundaries are tracked, so every frame warms up from scratch. It sits between the pixel DMA/stream source and the convolution MAC array.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 28, pixels per row (≥ K)
- IMG_HEIGHT, 28, rows per frame (≥ K)
- K, 3, kernel edge size (≥ 2)
- STRIDE, 1, horizontal and vertical window step (≥ 1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input pixel valid
- i_ready  out  1  block can accept a pixel
- i_data  in  DATA_WIDTH  pixel, raster order (x fastest)
- o_valid  out  1  window valid
- o_ready  in  1  downstream accepts window
- o_window  out  K*K × DATA_WIDTH (unpacked [0:K*K-1])  window; index r*K+c, r=0 top row, c=0 leftmost column
- o_x  out  $clog2(IMG_WIDTH)  window top-left column
- o_y  out  $clog2(IMG_HEIGHT)  window top-left row
- o_last  out  1  final window of the frame

## Operation
- Accept event: i_valid && i_ready. Nothing changes without an accept, except output handshake state.
- i_ready = !o_valid || o_ready (combinational). The single output register is the only buffering.
- K-1 line buffers, each IMG_WIDTH deep, chained. On accept, the pixel at column x from rows y-1 … y-(K-1) is read from the chain, and the new pixel is pushed.
- K×K window registers. Each row shifts one column left on accept, and the new rightmost column is loaded with the pixels of column x, rows y-(K-1) … y.
- Counters x_cnt (0…IMG_WIDTH-1) and y_cnt (0…IMG_HEIGHT-1) advance per accept. x wraps to 0 and increments y. At (W-1, H-1) both wrap to 0 (new frame).
- Line buffers and window registers are not cleared at frame wrap. Stale data is never emitted because of eligibility gating.
- Eligible position (x,y) requires all of the following:
  - x ≥ K-1 and y ≥ K-1
  - (x-(K-1)) % STRIDE == 0
  - (y-(K-1)) % STRIDE == 0
- On an accept at an eligible position, the output register loads:
  - window after the shift
  - o_x = x-(K-1), o_y = y-(K-1)
  - o_last = 1 if this is the last eligible x and last eligible y of the frame
  - o_valid = 1
- On an accept at a non-eligible position, o_valid clears, provided the previous window was consumed (guaranteed by the i_ready rule).
- o_valid && !o_ready: o_valid, o_window, o_x, o_y and o_last hold stable. i_ready = 0.
- Windows never straddle a row boundary (x gating) or a frame boundary (y gating, per-frame warmup).
- Windows per frame: ((IMG_WIDTH-K)/STRIDE+1) × ((IMG_HEIGHT-K)/STRIDE+1), integer division.

## Timing
- Reset values (async on rst assertion):
  - o_valid=0, o_last=0, o_x=0, o_y=0
  - all o_window elements 0, line buffers 0, counters 0
- i_ready while rst is high or after release: 1. Inputs are ignored while rst is high.
- Latency: pixel accepted at edge t produces its window with o_valid=1 after edge t, i.e. 1 cycle.
- Throughput: 1 pixel/cycle when o_ready=1 continuously.
- An output consumed (o_valid && o_ready) on the same edge as a new accept is replaced by the new result. No bubble, no loss.
- i_valid gaps: state frozen, o_valid clears after its window is consumed, counters and window resume unchanged.
- Reset mid-frame: all state is discarded. The next accepted pixel is (0,0) of a new frame.

## Test plan
- W=H=28, K=3, S=1, o_ready=1, pixel = (y*28+x)%256 → 676 windows.
  - First window: o_x=o_y=0, o_window = {0,1,2,28,29,30,56,57,58}, emitted 1 cycle after accepting pixel (2,2).
  - o_last only on the 676th window (o_x=o_y=25).
- Same stimulus with random o_ready (50%) and random i_valid gaps → same 676-window sequence as the first test.
  - Outputs stable while stalled.
  - No accept while i_ready=0.
- Two back-to-back 28×28 frames with distinct ramps.
  - Second frame emits no window until its pixel (2,2).
  - Exactly 676 windows per frame, none mixing frames.
- W=H=12, K=5, S=2 → 16 windows.
  - Origins (0,0),(2,0),(4,0),(6,0),(0,2)…(6,6).
  - o_last at (6,6).
- Assert rst after 100 pixels of a frame → all outputs 0 immediately.
  - A fresh frame afterwards yields the full, correct 676 windows starting at (0,0).
- K=2, S=1, W=H=4, ramp 0..15 → 9 windows.
  - First window {0,1,4,5}, last window {10,11,14,15} with o_last=1.

Source files
------------

// File: rtl/sliding_window_kxk.sv
// K x K sliding-window generator: raster-order pixel stream in, one flattened
// window per eligible (x, y) position out, with ready/valid on both sides.
module sliding_window_kxk #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int K          = 3,
    parameter int STRIDE     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [DATA_WIDTH-1:0]         o_window [0:K*K-1],
    output logic [$clog2(IMG_WIDTH)-1:0]  o_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_y,
    output logic                          o_last
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int NW = K * K;

    localparam logic [XW-1:0] X_MAX   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(K - 1 + ((IMG_WIDTH - K) / STRIDE) * STRIDE);
    localparam logic [YW-1:0] Y_LAST  = YW'(K - 1 + ((IMG_HEIGHT - K) / STRIDE) * STRIDE);

    logic [DATA_WIDTH-1:0] line_buf [0:K-2][0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] win      [0:NW-1];
    logic [DATA_WIDTH-1:0] win_nxt  [0:NW-1];
    logic [DATA_WIDTH-1:0] col      [0:K-1];
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic                  accept;
    logic                  x_ok;
    logic                  y_ok;
    logic                  eligible;

    assign i_ready  = !o_valid || o_ready;
    assign accept   = i_valid && i_ready;
    assign x_ok     = (x_cnt >= X_FIRST) && (((int'(x_cnt) - (K - 1)) % STRIDE) == 0);
    assign y_ok     = (y_cnt >= Y_FIRST) && (((int'(y_cnt) - (K - 1)) % STRIDE) == 0);
    assign eligible = x_ok && y_ok;

    // Column entering the window: line_buf[K-2] holds the oldest row, i_data the current one.
    always_comb begin
        col = '{default: '0};
        for (int unsigned r = 0; r < K - 1; r++) begin
            col[r] = line_buf[K - 2 - r][x_cnt];
        end
        col[K-1] = i_data;
    end

    always_comb begin
        win_nxt = '{default: '0};
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_nxt[r*K + c] = win[r*K + c + 1];
            end
            win_nxt[r*K + K - 1] = col[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < K - 1; i++) begin
                for (int unsigned j = 0; j < IMG_WIDTH; j++) begin
                    line_buf[i][j] <= '0;
                end
            end
            for (int unsigned i = 0; i < NW; i++) begin
                win[i]      <= '0;
                o_window[i] <= '0;
            end
            x_cnt   <= '0;
            y_cnt   <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
        end else if (accept) begin
            line_buf[0][x_cnt] <= i_data;
            for (int unsigned i = 1; i < K - 1; i++) begin
                line_buf[i][x_cnt] <= line_buf[i-1][x_cnt];
            end
            win <= win_nxt;

            if (x_cnt == X_MAX) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_MAX) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end

            // Non-eligible accepts only happen once the held window was taken.
            if (eligible) begin
                o_valid  <= 1'b1;
                o_window <= win_nxt;
                o_x      <= x_cnt - X_FIRST;
                o_y      <= y_cnt - Y_FIRST;
                o_last   <= (x_cnt == X_LAST) && (y_cnt == Y_LAST);
            end else begin
                o_valid <= 1'b0;
            end
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sliding_window_kxk.sv
// Randomized scoreboard bench for sliding_window_kxk over three geometries
// (28x28 K3 S1, 12x12 K5 S2, 4x4 K2 S1) with an image-formula reference.
module tb_sliding_window_kxk;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    typedef struct {
        int x;
        int y;
        bit last;
        int px[25];
    } exp_t;

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W    = (g == 0) ? 28 : (g == 1) ? 12 : 4;
        localparam int H    = W;
        localparam int K    = (g == 0) ? 3 : (g == 1) ? 5 : 2;
        localparam int S    = (g == 1) ? 2 : 1;
        localparam int XW   = $clog2(W);
        localparam int YW   = $clog2(H);
        localparam int NWIN = ((W - K) / S + 1) * ((H - K) / S + 1);
        localparam int PART = (W * H > 150) ? 100 : W * H / 2 + 1;

        logic          rst;
        logic          i_valid;
        logic          i_ready;
        logic [7:0]    i_data;
        logic          o_valid;
        logic          o_ready;
        logic [7:0]    o_window [0:K*K-1];
        logic [XW-1:0] o_x;
        logic [YW-1:0] o_y;
        logic          o_last;

        sliding_window_kxk #(
            .DATA_WIDTH(8),
            .IMG_WIDTH (W),
            .IMG_HEIGHT(H),
            .K         (K),
            .STRIDE    (S)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .i_valid (i_valid),
            .i_ready (i_ready),
            .i_data  (i_data),
            .o_valid (o_valid),
            .o_ready (o_ready),
            .o_window(o_window),
            .o_x     (o_x),
            .o_y     (o_y),
            .o_last  (o_last)
        );

        exp_t       q[$];
        int         mx, my, wins;
        bit         done;
        bit         pend, pend_el;
        int         pend_x, pend_y;
        bit         stalled;
        logic [7:0] sw [0:K*K-1];
        int         sx, sy;
        bit         sl;

        function automatic int pix(input int x, input int y, input int base);
            return (y * W + x + base) % 256;
        endfunction

        function automatic exp_t mk(input int ox, input int oy, input int base);
            exp_t e;
            e.x = ox;
            e.y = oy;
            e.last = (ox == ((W - K) / S) * S) && (oy == ((H - K) / S) * S);
            for (int i = 0; i < 25; i++) e.px[i] = 0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    e.px[r*K + c] = pix(ox + c, oy + r, base);
            return e;
        endfunction

        // Output of the previous accept must be visible one cycle later.
        task automatic check_latency();
            if (pend) begin
                if (pend_el)
                    chk(o_valid && o_x == XW'(pend_x) && o_y == YW'(pend_y), $sformatf("latency[%0d]", g),
                        $sformatf("got v=%0d (%0d,%0d) want v=1 (%0d,%0d)", o_valid, o_x, o_y, pend_x, pend_y));
                else
                    chk(!o_valid, $sformatf("noelig[%0d]", g), $sformatf("got v=%0d want v=0", o_valid));
            end
            pend = 0;
        endtask

        task automatic check_reset(input string tag);
            bit ok;
            ok = !o_valid && !o_last && o_x == '0 && o_y == '0 && i_ready;
            for (int i = 0; i < K*K; i++) if (o_window[i] != 8'd0) ok = 0;
            chk(ok, $sformatf("%s[%0d]", tag, g),
                $sformatf("got v=%0d last=%0d x=%0d y=%0d rdy=%0d w0=%0d want all 0, rdy=1",
                          o_valid, o_last, o_x, o_y, i_ready, o_window[0]));
        endtask

        task automatic frame(input int base, input int npix, input bit rv, input bit rr);
            int n, cyc;
            n = 0;
            cyc = 0;
            while (n < npix && cyc < npix * 20) begin
                @(posedge clk); #1;
                i_valid = rv ? ($urandom_range(3) != 0) : 1'b1;
                i_data  = 8'(pix(mx, my, base));
                o_ready = rr ? 1'($urandom_range(1)) : 1'b1;
                @(negedge clk);
                check_latency();
                if (i_valid && i_ready) begin
                    pend    = 1;
                    pend_el = mx >= K-1 && my >= K-1 && (mx-K+1) % S == 0 && (my-K+1) % S == 0;
                    pend_x  = mx - K + 1;
                    pend_y  = my - K + 1;
                    if (pend_el) q.push_back(mk(pend_x, pend_y, base));
                    n++;
                    mx++;
                    if (mx == W) begin
                        mx = 0;
                        my = (my == H - 1) ? 0 : my + 1;
                    end
                end
                cyc++;
            end
            chk(n == npix, $sformatf("pixel budget[%0d]", g), $sformatf("got %0d pixels want %0d", n, npix));
        endtask

        task automatic drain();
            int c;
            @(posedge clk); #1;
            i_valid = 0;
            o_ready = 1;
            @(negedge clk);
            check_latency();
            c = 0;
            while ((q.size() != 0 || o_valid) && c < 50) begin
                @(negedge clk);
                c++;
            end
            chk(q.size() == 0 && !o_valid, $sformatf("drain[%0d]", g),
                $sformatf("got pending=%0d v=%0d want 0,0", q.size(), o_valid));
        endtask

        initial begin : monitor
            forever begin
                @(negedge clk);
                if (rst) begin
                    stalled = 0;
                end else begin
                    chk(i_ready == (!o_valid || o_ready), $sformatf("i_ready[%0d]", g),
                        $sformatf("got %0d want %0d", i_ready, !o_valid || o_ready));
                    if (stalled) begin
                        bit same;
                        same = o_valid && o_x == XW'(sx) && o_y == YW'(sy) && o_last == sl;
                        for (int i = 0; i < K*K; i++) if (o_window[i] != sw[i]) same = 0;
                        chk(same, $sformatf("hold[%0d]", g),
                            $sformatf("got v=%0d (%0d,%0d) want v=1 (%0d,%0d)", o_valid, o_x, o_y, sx, sy));
                    end
                    if (o_valid && o_ready) begin
                        chk(q.size() != 0, $sformatf("unexpected[%0d]", g),
                            $sformatf("got window (%0d,%0d) want none", o_x, o_y));
                        if (q.size() != 0) begin
                            exp_t e;
                            bit ok;
                            int bad;
                            e = q.pop_front();
                            ok = o_x == XW'(e.x) && o_y == YW'(e.y) && o_last == e.last;
                            bad = -1;
                            for (int i = 0; i < K*K; i++)
                                if (o_window[i] != 8'(e.px[i])) begin ok = 0; bad = i; end
                            chk(ok, $sformatf("window[%0d]", g),
                                $sformatf("got (%0d,%0d) last=%0d badidx=%0d want (%0d,%0d) last=%0d",
                                          o_x, o_y, o_last, bad, e.x, e.y, e.last));
                            wins++;
                        end
                    end
                    stalled = o_valid && !o_ready;
                    sx = int'(o_x);
                    sy = int'(o_y);
                    sl = o_last;
                    sw = o_window;
                end
            end
        end

        initial begin : driver
            done = 0;
            pend = 0;
            rst = 1;
            i_valid = 0;
            i_data = '0;
            o_ready = 0;
            mx = 0;
            my = 0;
            repeat (2) @(negedge clk);
            check_reset("reset");
            @(posedge clk); #1 rst = 0;

            wins = 0;
            frame(0, W * H, 0, 0);
            drain();
            chk(wins == NWIN, $sformatf("count1[%0d]", g), $sformatf("got %0d want %0d", wins, NWIN));

            wins = 0;
            frame(0, W * H, 1, 1);
            drain();
            chk(wins == NWIN, $sformatf("count2[%0d]", g), $sformatf("got %0d want %0d", wins, NWIN));

            wins = 0;
            frame(100, W * H, 0, 0);
            frame(37, W * H, 0, 0);
            drain();
            chk(wins == 2 * NWIN, $sformatf("count3[%0d]", g), $sformatf("got %0d want %0d", wins, 2 * NWIN));

            frame(5, PART, 0, 0);
            @(posedge clk); #1;
            i_valid = 0;
            rst = 1;
            #1;
            check_reset("midreset");
            q.delete();
            pend = 0;
            mx = 0;
            my = 0;
            @(posedge clk); #1 rst = 0;
            wins = 0;
            frame(0, W * H, 1, 1);
            drain();
            chk(wins == NWIN, $sformatf("count4[%0d]", g), $sformatf("got %0d want %0d", wins, NWIN));
            done = 1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(cfg[0].done && cfg[1].done && cfg[2].done) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        chk(cfg[0].done && cfg[1].done && cfg[2].done, "completion",
            $sformatf("got done=%0d%0d%0d want 111", cfg[0].done, cfg[1].done, cfg[2].done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
